// File: rtl/modexp_engine.sv
// Modular exponentiation engine: right-to-left square-and-multiply over a bit-serial interleaved modmul.
// Optional MODEXP_EARLY_EXIT_EN skips zero-bit multiplies and stops at the last set exponent bit.
module modexp_engine #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_in,
    input  logic [WIDTH-1:0]     value_in,
    input  logic [WIDTH-1:0]     modulus_in,
    input  logic [EXP_WIDTH-1:0] exponent_in,
    output logic [WIDTH-1:0]     value_out,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic                 error_out
);

    // state    | meaning
    // S_IDLE   | waiting for start_in
    // S_REDUCE | base = value mod m
    // S_MUL    | result = result * base mod m (written only for a set exponent bit)
    // S_SQR    | base = base * base mod m, then exponent >> 1
    // S_DONE   | publish result, pulse valid_out
    typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_MUL, S_SQR, S_DONE} state_t;

    localparam int AW = WIDTH + 2;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    state_t               r_state, w_state_next;
    logic [WIDTH-1:0]     r_mod, r_base, r_result, r_opa, r_acc;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [CW-1:0]        r_cnt;
`ifndef MODEXP_EARLY_EXIT_EN
    localparam int BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    logic [BW-1:0]        r_bit_cnt;
`endif

    logic                 w_accept, w_last, w_unused_hi;
    logic [EXP_WIDTH-1:0] w_exp_shr;
    logic [WIDTH-1:0]     w_opb, w_prod, w_base_nxt, w_result_nxt, w_opa_load;
    logic [AW-1:0]        w_addend, w_sum, w_m, w_sub1, w_red;

    assign w_accept  = start_in && !busy_out;
    assign w_last    = (r_cnt == '0);
    assign w_exp_shr = r_exp >> 1;

    // One interleaved step: r = 2r + a_i*b, then at most two subtractions keep r < m.
    assign w_opb       = (r_state == S_REDUCE) ? WIDTH'(1) : r_base;
    assign w_addend    = r_opa[WIDTH-1] ? {2'b00, w_opb} : '0;
    assign w_sum       = {1'b0, r_acc, 1'b0} + w_addend;
    assign w_m         = {2'b00, r_mod};
    assign w_sub1      = (w_sum >= w_m) ? (w_sum - w_m) : w_sum;
    assign w_red       = (w_sub1 >= w_m) ? (w_sub1 - w_m) : w_sub1;
    assign w_prod      = w_red[WIDTH-1:0];
    assign w_unused_hi = |w_red[AW-1:WIDTH];

    assign w_base_nxt   = (w_last && (r_state == S_REDUCE || r_state == S_SQR)) ? w_prod : r_base;
    assign w_result_nxt = (w_last && r_state == S_MUL && r_exp[0]) ? w_prod : r_result;
    assign w_opa_load   = (w_state_next == S_MUL) ? w_result_nxt : w_base_nxt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = (modulus_in == '0) ? S_DONE : S_REDUCE;
            S_REDUCE: if (w_last) begin
`ifdef MODEXP_EARLY_EXIT_EN
                if (r_exp == '0)  w_state_next = S_DONE;
                else if (r_exp[0]) w_state_next = S_MUL;
                else               w_state_next = S_SQR;
`else
                w_state_next = S_MUL;
`endif
            end
            S_MUL:    if (w_last) begin
`ifdef MODEXP_EARLY_EXIT_EN
                w_state_next = (w_exp_shr == '0) ? S_DONE : S_SQR;
`else
                w_state_next = S_SQR;
`endif
            end
            S_SQR:    if (w_last) begin
`ifdef MODEXP_EARLY_EXIT_EN
                w_state_next = w_exp_shr[0] ? S_MUL : S_SQR;
`else
                w_state_next = (r_bit_cnt == '0) ? S_DONE : S_MUL;
`endif
            end
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_mod     <= '0;
            r_base    <= '0;
            r_result  <= '0;
            r_opa     <= '0;
            r_acc     <= '0;
            r_exp     <= '0;
            r_cnt     <= '0;
`ifndef MODEXP_EARLY_EXIT_EN
            r_bit_cnt <= '0;
`endif
            value_out <= '0;
            busy_out  <= 1'b0;
            valid_out <= 1'b0;
            error_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_mod     <= modulus_in;
                    r_exp     <= exponent_in;
                    r_opa     <= value_in;
                    r_acc     <= '0;
                    r_cnt     <= CNT_MAX;
                    r_base    <= '0;
                    r_result  <= (modulus_in == WIDTH'(1)) ? '0 : WIDTH'(1);
`ifndef MODEXP_EARLY_EXIT_EN
                    r_bit_cnt <= BW'(EXP_WIDTH - 1);
`endif
                    busy_out  <= 1'b1;
                    error_out <= 1'b0;
                end
                S_REDUCE, S_MUL, S_SQR: begin
                    r_base   <= w_base_nxt;
                    r_result <= w_result_nxt;
                    if (w_last) begin
                        r_acc <= '0;
                        r_cnt <= CNT_MAX;
                        r_opa <= w_opa_load;
                        if (r_state == S_SQR) begin
                            r_exp <= w_exp_shr;
`ifndef MODEXP_EARLY_EXIT_EN
                            r_bit_cnt <= r_bit_cnt - 1'b1;
`endif
                        end
                    end else begin
                        r_acc <= w_prod;
                        r_cnt <= r_cnt - 1'b1;
                        r_opa <= r_opa << 1;
                    end
                end
                S_DONE: begin
                    value_out <= (r_mod == '0) ? '0 : r_result;
                    error_out <= (r_mod == '0);
                    valid_out <= 1'b1;
                    busy_out  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
